// File: rtl/uart_rom_loader.sv
// uart_rom_loader: turns a length-prefixed byte stream into 16-bit instruction
// words and hands each one to the Hack SoC ROM port with an sck/ack handshake.
// Optional feature: define ROM_LOADER_CHECKSUM_EN to expect a trailing
// big-endian 16-bit wrapping sum of all data words after the last word.
module uart_rom_loader #(
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        rom_loader_load,
  output logic        rom_loader_sck,
  output logic [15:0] rom_loader_data,
  input  logic        rom_loader_ack,
  output logic        busy,
  output logic        done,
  output logic [15:0] words_loaded,
  output logic        timeout_error,
  output logic        checksum_error
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LEN_LO   = 4'd1,
    S_WORD_HI  = 4'd2,
    S_WORD_LO  = 4'd3,
    S_SCK_HIGH = 4'd4,
    S_SCK_LOW  = 4'd5,
    S_DONE     = 4'd6,
    S_ERROR    = 4'd7
`ifdef ROM_LOADER_CHECKSUM_EN
    ,
    S_CSUM_HI  = 4'd8,
    S_CSUM_LO  = 4'd9
`endif
  } state_t;

  // The handshake watchdog fires when it has spent this many cycles waiting.
  localparam logic [31:0] LP_ACK_LAST = 32'(ACK_TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_lenHi;
  logic [15:0] r_len;
  logic [7:0]  r_wordHi;
  logic [15:0] r_data;
  logic        r_sck;
  logic        r_load;
  logic        r_done;
  logic [15:0] r_words;
  logic        r_timeout;
  logic [31:0] r_ackCnt;
  logic        w_ready;
  logic        w_accept;
  logic [15:0] w_word;
  logic [15:0] w_len;

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0] r_sum;
  logic [7:0]  r_csumHi;
  logic        r_csumErr;
`endif

  assign w_accept = byte_valid && w_ready;
  assign w_word   = {r_wordHi, byte_data};
  assign w_len    = {r_lenHi, byte_data};

  // Byte acceptance and busy indication are decoded straight from the state.
  always_comb begin
    w_ready = 1'b0;
    busy    = 1'b1;
    case (r_state)
      S_IDLE, S_LEN_LO, S_WORD_HI, S_WORD_LO: w_ready = 1'b1;
`ifdef ROM_LOADER_CHECKSUM_EN
      S_CSUM_HI, S_CSUM_LO:                   w_ready = 1'b1;
`endif
      default:                                w_ready = 1'b0;
    endcase
    if (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR) begin
      busy = 1'b0;
    end
  end

  // Session sequencer: header parse, word assembly, handshake, trailer, errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_lenHi   <= 8'd0;
      r_len     <= 16'd0;
      r_wordHi  <= 8'd0;
      r_data    <= 16'd0;
      r_sck     <= 1'b0;
      r_load    <= 1'b0;
      r_done    <= 1'b0;
      r_words   <= 16'd0;
      r_timeout <= 1'b0;
      r_ackCnt  <= 32'd0;
`ifdef ROM_LOADER_CHECKSUM_EN
      r_sum     <= 16'd0;
      r_csumHi  <= 8'd0;
      r_csumErr <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_lenHi <= byte_data;
            r_words <= 16'd0;
`ifdef ROM_LOADER_CHECKSUM_EN
            r_sum   <= 16'd0;
`endif
            r_state <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_len <= w_len;
            if (w_len == 16'd0) begin
`ifdef ROM_LOADER_CHECKSUM_EN
              r_state <= S_CSUM_HI;
`else
              r_done  <= 1'b1;
              r_state <= S_DONE;
`endif
            end else begin
              r_load  <= 1'b1;
              r_state <= S_WORD_HI;
            end
          end
        end
        S_WORD_HI: begin
          if (w_accept) begin
            r_wordHi <= byte_data;
            r_state  <= S_WORD_LO;
          end
        end
        S_WORD_LO: begin
          if (w_accept) begin
            r_data   <= w_word;
            r_sck    <= 1'b1;
            r_ackCnt <= 32'd0;
`ifdef ROM_LOADER_CHECKSUM_EN
            r_sum    <= r_sum + w_word;
`endif
            r_state  <= S_SCK_HIGH;
          end
        end
        S_SCK_HIGH: begin
          if (rom_loader_ack) begin
            r_sck    <= 1'b0;
            r_words  <= r_words + 16'd1;
            r_ackCnt <= 32'd0;
            r_state  <= S_SCK_LOW;
          end else if (r_ackCnt == LP_ACK_LAST) begin
            r_timeout <= 1'b1;
            r_sck     <= 1'b0;
            r_load    <= 1'b0;
            r_state   <= S_ERROR;
          end else begin
            r_ackCnt <= r_ackCnt + 32'd1;
          end
        end
        S_SCK_LOW: begin
          if (!rom_loader_ack) begin
            r_ackCnt <= 32'd0;
            if (r_words == r_len) begin
              r_load <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
              r_state <= S_CSUM_HI;
`else
              r_done  <= 1'b1;
              r_state <= S_DONE;
`endif
            end else begin
              r_state <= S_WORD_HI;
            end
          end else if (r_ackCnt == LP_ACK_LAST) begin
            r_timeout <= 1'b1;
            r_sck     <= 1'b0;
            r_load    <= 1'b0;
            r_state   <= S_ERROR;
          end else begin
            r_ackCnt <= r_ackCnt + 32'd1;
          end
        end
`ifdef ROM_LOADER_CHECKSUM_EN
        S_CSUM_HI: begin
          if (w_accept) begin
            r_csumHi <= byte_data;
            r_state  <= S_CSUM_LO;
          end
        end
        S_CSUM_LO: begin
          if (w_accept) begin
            if ({r_csumHi, byte_data} == r_sum) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_csumErr <= 1'b1;
              r_state   <= S_ERROR;
            end
          end
        end
`endif
        S_DONE: begin
          r_state <= S_IDLE;
        end
        S_ERROR: begin
          r_load <= 1'b0;
          r_sck  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign byte_ready      = w_ready;
  assign rom_loader_load = r_load;
  assign rom_loader_sck  = r_sck;
  assign rom_loader_data = r_data;
  assign done            = r_done;
  assign words_loaded    = r_words;
  assign timeout_error   = r_timeout;
`ifdef ROM_LOADER_CHECKSUM_EN
  assign checksum_error  = r_csumErr;
`else
  assign checksum_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rom_loader.sv
// tb_uart_rom_loader: directed and randomized sessions for uart_rom_loader,
// checked against a word-list model of the expected stream contents.
// Honours ROM_LOADER_CHECKSUM_EN the same way the design does.
module tb_uart_rom_loader;

  localparam int TB_TIMEOUT = 20;
  localparam int WAIT_BUDGET = 500;

  typedef logic [15:0] wordq_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        rom_loader_load;
  logic        rom_loader_sck;
  logic [15:0] rom_loader_data;
  logic        rom_loader_ack;
  logic        busy;
  logic        done;
  logic [15:0] words_loaded;
  logic        timeout_error;
  logic        checksum_error;

  int testCount = 0;
  int failCount = 0;

  int   ackDelay  = 2;
  logic ackEnable = 1'b0;

  logic [15:0] seenWords[$];
  int          doneCount    = 0;
  int          sckNoLoad    = 0;
  int          dataUnstable = 0;
  int          loadCycles   = 0;
  logic        prevSck      = 1'b0;
  logic [15:0] prevData     = 16'd0;

  uart_rom_loader #(.ACK_TIMEOUT(TB_TIMEOUT)) dut (
    .clk             (clk),
    .reset           (reset),
    .byte_data       (byte_data),
    .byte_valid      (byte_valid),
    .byte_ready      (byte_ready),
    .rom_loader_load (rom_loader_load),
    .rom_loader_sck  (rom_loader_sck),
    .rom_loader_data (rom_loader_data),
    .rom_loader_ack  (rom_loader_ack),
    .busy            (busy),
    .done            (done),
    .words_loaded    (words_loaded),
    .timeout_error   (timeout_error),
    .checksum_error  (checksum_error)
  );

  always #5 clk = ~clk;

  // Observe the ROM port: capture each presented word and flag protocol slips.
  always @(negedge clk) begin
    if (rom_loader_sck && !prevSck) seenWords.push_back(rom_loader_data);
    if (rom_loader_sck && prevSck && rom_loader_data !== prevData) dataUnstable <= dataUnstable + 1;
    if (rom_loader_sck && !rom_loader_load) sckNoLoad <= sckNoLoad + 1;
    if (done === 1'b1) doneCount <= doneCount + 1;
    if (rom_loader_load === 1'b1) loadCycles <= loadCycles + 1;
    prevSck  <= rom_loader_sck;
    prevData <= rom_loader_data;
  end

  // SoC side: raise ack ackDelay cycles after sck rises, drop it ackDelay cycles after sck falls.
  initial begin
    int cnt;
    cnt = 0;
    rom_loader_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!ackEnable) begin
        rom_loader_ack = 1'b0;
        cnt = 0;
      end else if (rom_loader_sck && !rom_loader_ack) begin
        cnt++;
        if (cnt >= ackDelay) begin
          rom_loader_ack = 1'b1;
          cnt = 0;
        end
      end else if (!rom_loader_sck && rom_loader_ack) begin
        cnt++;
        if (cnt >= ackDelay) begin
          rom_loader_ack = 1'b0;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one byte after an idle gap; returns on the negedge after it is taken.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int tries;
    byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    tries = 0;
    while (byte_ready !== 1'b1 && tries < WAIT_BUDGET) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= WAIT_BUDGET) checkOutput("byte_accept_wait", 32'(tries), 32'(WAIT_BUDGET - 1));
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  // Reference model: the byte stream for a given word list.
  function automatic void buildStream(input wordq_t words, input logic [15:0] csum, output logic [7:0] bytes[$]);
    int n;
    n = words.size();
    bytes = {};
    bytes.push_back(8'(n / 256));
    bytes.push_back(8'(n % 256));
    foreach (words[i]) begin
      bytes.push_back(8'(words[i] / 256));
      bytes.push_back(8'(words[i] % 256));
    end
`ifdef ROM_LOADER_CHECKSUM_EN
    bytes.push_back(8'(csum / 256));
    bytes.push_back(8'(csum % 256));
`else
    if (csum == 16'hFFFF) bytes.push_back(8'h00);
    bytes = bytes[0:2*n+1];
`endif
  endfunction

  function automatic logic [15:0] modelSum(input wordq_t words);
    int s;
    s = 0;
    foreach (words[i]) s = (s + int'(words[i])) % 65536;
    return 16'(s);
  endfunction

  task automatic runSession(input string tag, input wordq_t words, input int gapMax);
    logic [7:0] bytes[$];
    int startSeen, startDone, startLoad, startUns, startNoLoad, waited, mism, n;
    n = words.size();
    buildStream(words, modelSum(words), bytes);
    startSeen   = seenWords.size();
    startDone   = doneCount;
    startLoad   = loadCycles;
    startUns    = dataUnstable;
    startNoLoad = sckNoLoad;
    foreach (bytes[i]) begin
      applyStimulus(bytes[i], (gapMax > 0) ? $urandom_range(gapMax, 0) : 0);
      if (i == 0) checkOutput({tag, "_wl_cleared"}, 32'(words_loaded), 32'd0);
    end
    waited = 0;
    while (done !== 1'b1 && waited < WAIT_BUDGET) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, "_done_seen"}, 32'(waited < WAIT_BUDGET), 32'd1);
    checkOutput({tag, "_words_loaded"}, 32'(words_loaded), 32'(n));
    @(negedge clk);
    checkOutput({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    checkOutput({tag, "_idle_outputs"}, {28'd0, busy, rom_loader_load, rom_loader_sck, byte_ready}, 32'h1);
    repeat (3) @(negedge clk);
    checkOutput({tag, "_wl_retained"}, 32'(words_loaded), 32'(n));
    checkOutput({tag, "_done_pulses"}, 32'(doneCount - startDone), 32'd1);
    checkOutput({tag, "_word_count"}, 32'(seenWords.size() - startSeen), 32'(n));
    mism = 0;
    for (int i = 0; i < n && startSeen + i < seenWords.size(); i++)
      if (seenWords[startSeen + i] !== words[i]) mism++;
    checkOutput({tag, "_word_values"}, 32'(mism), 32'd0);
    checkOutput({tag, "_data_stable"}, 32'(dataUnstable - startUns), 32'd0);
    checkOutput({tag, "_sck_needs_load"}, 32'(sckNoLoad - startNoLoad), 32'd0);
    if (n == 0) checkOutput({tag, "_load_never"}, 32'(loadCycles - startLoad), 32'd0);
    else checkOutput({tag, "_load_span"}, 32'(loadCycles - startLoad >= n), 32'd1);
    checkOutput({tag, "_no_errors"}, {30'd0, timeout_error, checksum_error}, 32'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    wordq_t words;
    logic [7:0] bytes[$];
    int waited, startSeen;

    reset = 1'b1;
    byte_valid = 1'b0;
    byte_data = 8'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", 32'(byte_ready), 32'd1);
    checkOutput("reset_port", {15'd0, rom_loader_load, rom_loader_sck, rom_loader_data}, 32'd0);
    checkOutput("reset_status", {13'd0, busy, done, words_loaded, timeout_error, checksum_error}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    ackEnable = 1'b1;
    ackDelay = 2;
    words = '{16'h1234, 16'hABCD};
    runSession("basic", words, 0);

    words = {};
    runSession("empty", words, 0);

    for (int s = 0; s < 4; s++) begin
      words = {};
      repeat ($urandom_range(6, 1)) words.push_back(16'($urandom));
      ackDelay = $urandom_range(3, 0);
      runSession("random", words, 3);
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    ackDelay = 2;
    applyStimulus(8'h00, 0); applyStimulus(8'h01, 0);
    applyStimulus(8'h00, 0); applyStimulus(8'h05, 0);
    applyStimulus(8'h00, 0); applyStimulus(8'h06, 0);
    @(negedge clk);
    checkOutput("csum_bad_flag", 32'(checksum_error), 32'd1);
    checkOutput("csum_bad_state", {29'd0, busy, byte_ready, rom_loader_load}, 32'd0);
    doReset();
    words = '{16'h0005};
    runSession("csum_good", words, 1);
`endif

    // Abort a five-word session while word 3 is on the port.
    ackDelay = 2;
    words = {};
    repeat (5) words.push_back(16'($urandom));
    buildStream(words, modelSum(words), bytes);
    startSeen = seenWords.size();
    for (int i = 0; i < 8; i++) applyStimulus(bytes[i], $urandom_range(2, 0));
    waited = 0;
    while (rom_loader_sck !== 1'b1 && waited < WAIT_BUDGET) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("abort_sck_wait", 32'(waited < WAIT_BUDGET), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_port_drop", {30'd0, rom_loader_load, rom_loader_sck}, 32'd0);
    checkOutput("abort_wl", 32'(words_loaded), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_word3", 32'(seenWords[startSeen + 2]), 32'(words[2]));
    words = {};
    repeat (5) words.push_back(16'($urandom));
    runSession("after_abort", words, 2);

    // Never acknowledge: the watchdog must trip.
    ackEnable = 1'b0;
    applyStimulus(8'h00, 0); applyStimulus(8'h01, 0);
    applyStimulus(8'($urandom), 0); applyStimulus(8'($urandom), 0);
    waited = 0;
    while (rom_loader_sck !== 1'b1 && waited < WAIT_BUDGET) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("to_sck_wait", 32'(waited < WAIT_BUDGET), 32'd1);
    waited = 0;
    while (timeout_error !== 1'b1 && waited < 3 * TB_TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("to_latency", 32'(waited >= TB_TIMEOUT - 1 && waited <= TB_TIMEOUT + 1), 32'd1);
    byte_valid = 1'b1;
    byte_data = 8'h55;
    repeat (10) @(negedge clk);
    checkOutput("to_error_hold", {27'd0, timeout_error, busy, rom_loader_load, rom_loader_sck, byte_ready}, 32'h10);
    checkOutput("to_wl", 32'(words_loaded), 32'd0);
    byte_valid = 1'b0;
    doReset();
    checkOutput("to_reset_clear", 32'(timeout_error), 32'd0);
    ackEnable = 1'b1;
    words = '{16'hBEEF};
    runSession("after_timeout", words, 1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
